// File: rtl/invsqrt_pkg.sv
// Shared constants, tag type and helpers for the inverse-square-root scheduler.
// INVSQRT_SCHED_GUARD_EN adds an operand-invalid flag to the tag.
package invsqrt_pkg;

    localparam int                 FLOAT_W  = 32;
    localparam logic [FLOAT_W-1:0] QNAN     = 32'h7fc00000;
    localparam int                 TAG_ID_W = 4;

    typedef struct packed {
`ifdef INVSQRT_SCHED_GUARD_EN
        logic                bad;
`endif
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

`ifdef INVSQRT_SCHED_GUARD_EN
    // Negative operands and zero/denormal exponents have no meaningful 1/sqrt.
    function automatic logic is_bad_operand(input logic [FLOAT_W-1:0] x);
        return x[FLOAT_W-1] | (x[30:23] == 8'h00);
    endfunction
`endif

endpackage

// File: rtl/invsqrt_rsp_fifo.sv
// Response buffer: circular FIFO of {id, result}; head is shown combinationally
// and forced to zero when empty so reset leaves the outputs at zero.
module invsqrt_rsp_fifo
    import invsqrt_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ID_W-1:0]          push_id,
    input  logic [FLOAT_W-1:0]       push_data,
    input  logic                     pop_ready,
    output logic                     out_valid,
    output logic [ID_W-1:0]          out_id,
    output logic [FLOAT_W-1:0]       out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ID_W+FLOAT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    pop;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & pop_ready;
    assign count     = count_q;
    assign {out_id, out_data} = out_valid ? mem[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {push_id, push_data};
        end
    end

endmodule

// File: rtl/invsqrt_scheduler.sv
// Round-robin front end sharing one pipelined InvertSQRoot datapath among NUM_REQ
// requesters. Define INVSQRT_SCHED_GUARD_EN to return QNAN for invalid operands.
module invsqrt_scheduler
    import invsqrt_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DP_LAT    = 4,
    parameter  int RSP_DEPTH = 8,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [FLOAT_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [FLOAT_W-1:0]         dp_data_in,
    input  logic [FLOAT_W-1:0]         dp_data_out,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [FLOAT_W-1:0]         rsp_data,
    output logic                       busy
);

    localparam int FC_W  = $clog2(RSP_DEPTH) + 1;
    localparam int CNT_W = FC_W + 1;

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [FLOAT_W-1:0] dp_data_q, dp_data_d;
    tag_t               tag_q [DP_LAT];
    tag_t               tag_d [DP_LAT];
    tag_t               new_tag, out_tag;
    logic [DP_LAT-1:0]  tag_valid;
    logic [FC_W-1:0]    fifo_count;
    logic [CNT_W-1:0]   in_flight;
    logic               credit_ok, grant_found, accept;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W:0]      scan_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [FLOAT_W-1:0] grant_data;
    logic [FLOAT_W-1:0] push_data;
    logic               unused_tag_id;

    assign in_flight = CNT_W'($countones(tag_valid));
    // A response popped this cycle is not yet counted as free space.
    assign credit_ok = (in_flight + CNT_W'(fifo_count)) < CNT_W'(RSP_DEPTH);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        grant_oh    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[scan_idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[ID_W-1:0];
            end
        end
        if (grant_found && credit_ok && rst) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign req_ready  = grant_oh;
    assign accept     = |grant_oh;
    assign grant_data = req_data[grant_idx*FLOAT_W +: FLOAT_W];

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        dp_data_d = dp_data_q;
        new_tag   = '0;
        if (accept) begin
            rr_ptr_d  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            dp_data_d = grant_data;
        end
        new_tag.valid = accept;
        new_tag.id    = TAG_ID_W'(grant_idx);
`ifdef INVSQRT_SCHED_GUARD_EN
        new_tag.bad   = accept & is_bad_operand(grant_data);
`endif
    end

    assign tag_d[0] = new_tag;
    for (genvar gi = 1; gi < DP_LAT; gi++) begin : g_tag_shift
        assign tag_d[gi] = tag_q[gi-1];
    end
    for (genvar gi = 0; gi < DP_LAT; gi++) begin : g_tag_valid
        assign tag_valid[gi] = tag_q[gi].valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q  <= '0;
            dp_data_q <= '0;
            for (int s = 0; s < DP_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            dp_data_q <= dp_data_d;
            for (int s = 0; s < DP_LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    assign dp_data_in = dp_data_q;
    // The last tag stage lines up with the datapath result of the same operand.
    assign out_tag       = tag_q[DP_LAT-1];
    assign unused_tag_id = ^out_tag.id;

`ifdef INVSQRT_SCHED_GUARD_EN
    assign push_data = out_tag.bad ? QNAN : dp_data_out;
`else
    assign push_data = dp_data_out;
`endif

    invsqrt_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .ID_W  (ID_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (out_tag.valid),
        .push_id   (out_tag.id[ID_W-1:0]),
        .push_data (push_data),
        .pop_ready (rsp_ready),
        .out_valid (rsp_valid),
        .out_id    (rsp_id),
        .out_data  (rsp_data),
        .count     (fifo_count)
    );

    assign busy = (|tag_valid) | (fifo_count != '0);

endmodule

// File: doc/invsqrt_scheduler.md
INVSQRT_SCHEDULER -- requirements
Module: invsqrt_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (1..16).
REQ-002 SHALL have parameter DP_LAT, default 4, clock edges from the edge loading dp_data_in to valid dp_data_out (>=1).
REQ-003 SHALL have parameter RSP_DEPTH, default 8, response buffer entries (power of 2, >= DP_LAT).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester operand valid.
REQ-007 SHALL have port req_data  input  32*NUM_REQ  IEEE-754 single operands, requester i in bits [32i+31:32i].
REQ-008 SHALL have port req_ready  output  NUM_REQ  one-hot grant/accept.
REQ-009 SHALL have port dp_data_in  output  32  operand to shared InvertSQRoot DataIn.
REQ-010 SHALL have port dp_data_out  input  32  result from shared InvertSQRoot DataOut.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  response consumed.
REQ-013 SHALL have port rsp_id  output  $clog2(NUM_REQ) (min 1)  requester index of response.
REQ-014 SHALL have port rsp_data  output  32  result value.
REQ-015 SHALL have port busy  output  1  any operation in flight or buffered.

Function
REQ-016 SHALL arbitrate round-robin: grant lowest index at or after rr_ptr with req_valid set; rr_ptr <= granted index + 1 (wrapping NUM_REQ-1 -> 0) on each accept.
REQ-017 SHALL assert at most one req_ready bit per cycle, only for a valid requester and only when in_flight + fifo_count < RSP_DEPTH (same-cycle pop not credited).
REQ-018 SHALL accept when req_valid[i] & req_ready[i] at a rising edge; that edge loads dp_data_in with req_data[i] and pushes tag {valid=1,id=i} into a DP_LAT-stage tag shift register.
REQ-019 SHALL hold dp_data_in unchanged in cycles without an accept.
REQ-020 SHALL, at the edge where a valid tag leaves stage DP_LAT, write {id, dp_data_out} into the response FIFO; result visible on rsp_* one cycle later when FIFO was empty.
REQ-021 SHALL sustain one accept per cycle back-to-back while credit remains; responses return in accept order.
REQ-022 SHALL pop FIFO when rsp_valid & rsp_ready; simultaneous push and pop SHALL both take effect, count unchanged.
REQ-023 SHALL hold rsp_id/rsp_data stable while rsp_valid & !rsp_ready.
REQ-024 SHALL wrap FIFO read/write pointers modulo RSP_DEPTH; overflow is impossible by REQ-017.
REQ-025 SHALL drive busy = (any tag valid) | (fifo_count != 0).

Reset
REQ-026 SHALL, on rst low, asynchronously clear rr_ptr, all tags, FIFO pointers/count, dp_data_in (32'h0), req_ready, rsp_valid, rsp_id, rsp_data, busy.
REQ-027 SHALL discard in-flight and buffered results on reset mid-operation; no response emitted for them after release.

Configuration
REQ-028 SHALL, with INVSQRT_SCHED_GUARD_EN defined, mark operands with sign bit 1 or exponent 0 as invalid in the tag and replace their result with 32'h7fc00000 at FIFO write; order and latency unchanged.
REQ-029 SHALL, without INVSQRT_SCHED_GUARD_EN, pass dp_data_out unmodified for all operands and omit the flag bit from the tag.

Structure
REQ-030 SHALL place FLOAT_W=32, QNAN=32'h7fc00000 and the tag struct typedef in shared package invsqrt_pkg.
REQ-031 SHALL implement the response buffer as sub-module invsqrt_rsp_fifo; arbiter and tag pipeline stay in the top.

Verification
REQ-032 SHALL cover: single request 0: 32'h3f800000 (1.0), rsp_ready=1 -> rsp_valid after DP_LAT+1 edges, rsp_id=0, rsp_data = bench model result (~1.0).
REQ-033 SHALL cover: all 4 requesters valid continuously (3dcccccd, 3efae148, 3f800000, 40800000) -> grants 0,1,2,3,0,... one per cycle, rsp_id same order.
REQ-034 SHALL cover: rsp_ready=0 with continuous requests -> exactly 8 accepts, req_ready then 0; raising rsp_ready resumes accepts; no lost or duplicated response.
REQ-035 SHALL cover: rst low for 1 cycle while 3 in flight and 2 buffered -> outputs zero, busy=0, no stale response afterwards, next grant to requester 0.
REQ-036 SHALL cover: with INVSQRT_SCHED_GUARD_EN, operands 32'hbf800000 and 32'h00000000 -> rsp_data 32'h7fc00000 in order; without the macro -> rsp_data equals dp_data_out.
